alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the core's single-cycle ALU. Width is generalised to XLEN.
- Opcode space widens to 4 bits. Adds sra and sltu, plus iterative multiply and unsigned divide/remainder (RV32M subset).
- Valid/ready handshake on the input; registered result with a one-cycle out_valid pulse.
- Sits in the EX stage; the hazard unit stalls the pipeline while in_ready is low.

---
 rtl/alu_mc.sv | 196 +++++++++++++++++++
 tb/tb_alu_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc - multi-cycle ALU for the EX stage.
//
// Single-cycle ops (add/sub/logic/compare/shifts) complete on the cycle after
// accept. mul/mulhu use shift-add and divu/remu use restoring division, one
// bit per cycle, so they complete XLEN+1 cycles after accept. The hazard unit
// stalls the pipeline while in_ready is low.
//
// Optional feature: define ALU_SIGNED_MD_EN to enable signed div (1110) and
// rem (1111). Without it those opcodes act as illegal (result 0, one cycle).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready request handshake (accept = in_valid && in_ready)
//   alucontrol, a, b  operation select and operands, latched on accept
//   flush             aborts the in-flight operation
//   out_valid         one-cycle completion pulse
//   result, zero      registered result and (result == 0), held between ops
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            accept;

  // iterative datapath: hi = partial product high / remainder,
  // lo = multiplier / dividend shifting into quotient
  logic [3:0]      op_p0;
  logic [XLEN-1:0] opa_p0, opb_p0, hi_p0, lo_p0;
  logic [XLEN-1:0] hi_nx, lo_nx, iter_res;
  logic [XLEN:0]   mul_sum, div_sh, div_trial;

  logic signed [XLEN-1:0] sa, sb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] fast_res, ld_a, ld_b;
  logic            is_iter;

`ifdef ALU_SIGNED_MD_EN
  logic            ld_neg_q, ld_neg_r, neg_q_p0, neg_r_p0;
  logic            overflow;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? ({XLEN{1'b0}} - v) : v;
  endfunction

  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ({XLEN{1'b0}} - v) : v;
  endfunction

  assign overflow = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});
`endif

  assign sa       = a;
  assign sb       = b;
  assign shamt    = b[SHW-1:0];
  assign in_ready = ((state == IDLE) || (state == DONE)) && !flush;
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == DONE);

  // decode: single-cycle result, or operands to load into the iterative engine
  always_comb begin
    fast_res = '0;
    is_iter  = 1'b0;
    ld_a     = a;
    ld_b     = b;
`ifdef ALU_SIGNED_MD_EN
    ld_neg_q = 1'b0;
    ld_neg_r = 1'b0;
`endif
    case (alucontrol)
      4'b0000: fast_res = a + b;
      4'b0001: fast_res = a - b;
      4'b0010: fast_res = a & b;
      4'b0011: fast_res = a | b;
      4'b0100: fast_res = a ^ b;
      4'b0101: fast_res = {{(XLEN-1){1'b0}}, (sa < sb)};
      4'b0110: fast_res = a << shamt;
      4'b0111: fast_res = a >> shamt;
      4'b1000: fast_res = sa >>> shamt;
      4'b1001: fast_res = {{(XLEN-1){1'b0}}, (a < b)};
      4'b1010, 4'b1011: is_iter = 1'b1;
      4'b1100: if (b == '0) fast_res = '1; else is_iter = 1'b1;
      4'b1101: if (b == '0) fast_res = a;  else is_iter = 1'b1;
`ifdef ALU_SIGNED_MD_EN
      4'b1110, 4'b1111: begin
        if (b == '0)
          fast_res = alucontrol[0] ? a : '1;
        else if (overflow)
          fast_res = alucontrol[0] ? '0 : a;
        else begin
          is_iter  = 1'b1;
          ld_a     = mag(a);
          ld_b     = mag(b);
          ld_neg_q = a[XLEN-1] ^ b[XLEN-1];
          ld_neg_r = a[XLEN-1];
        end
      end
`endif
      default: fast_res = '0;
    endcase
  end

  // one iteration step of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi_p0} + {1'b0, (lo_p0[0] ? opa_p0 : {XLEN{1'b0}})};
    div_sh    = {hi_p0, lo_p0[XLEN-1]};
    div_trial = div_sh - {1'b0, opb_p0};
    if (op_p0[3:1] == 3'b101) begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_p0[XLEN-1:1]};
    end else if (!div_trial[XLEN]) begin
      hi_nx = div_trial[XLEN-1:0];
      lo_nx = {lo_p0[XLEN-2:0], 1'b1};
    end else begin
      hi_nx = div_sh[XLEN-1:0];
      lo_nx = {lo_p0[XLEN-2:0], 1'b0};
    end
`ifdef ALU_SIGNED_MD_EN
    iter_res = op_p0[0] ? sign_fix(hi_nx, neg_r_p0) : sign_fix(lo_nx, neg_q_p0);
`else
    iter_res = op_p0[0] ? hi_nx : lo_nx;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = is_iter ? BUSY : DONE;
        else        state_nx = IDLE;
      end
      BUSY:    if (cnt == CW'(1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_nx;
      if (flush)                  cnt <= '0;
      else if (accept && is_iter) cnt <= CW'(XLEN);
      else if (state == BUSY)     cnt <= cnt - CW'(1);
      if (!flush) begin
        if (accept && !is_iter) begin
          result <= fast_res;
          zero   <= (fast_res == '0);
        end else if ((state == BUSY) && (cnt == CW'(1))) begin
          result <= iter_res;
          zero   <= (iter_res == '0);
        end
      end
    end
  end

  // stage p0: operand capture on accept, then one step per BUSY cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= alucontrol;
      opa_p0 <= ld_a;
      opb_p0 <= ld_b;
      hi_p0  <= '0;
      lo_p0  <= (alucontrol[3:1] == 3'b101) ? b : ld_a;
`ifdef ALU_SIGNED_MD_EN
      neg_q_p0 <= ld_neg_q;
      neg_r_p0 <= ld_neg_r;
`endif
    end else if (state == BUSY) begin
      hi_p0 <= hi_nx;
      lo_p0 <= lo_nx;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, zero;
  logic [3:0]  alucontrol;
  logic [31:0] a, b, result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  alu_mc #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0]        p;
    logic signed [31:0] s;
    logic [31:0]        r;
    p = {32'd0, x} * {32'd0, y};
    r = 32'd0;
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  if ($signed(x) < $signed(y)) r = 32'd1;
      4'd6:  r = x << y[4:0];
      4'd7:  r = x >> y[4:0];
      4'd8:  begin s = $signed(x) >>> y[4:0]; r = s; end
      4'd9:  if (x < y) r = 32'd1;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: if (y == 0) r = 32'hFFFF_FFFF; else r = x / y;
      4'd13: if (y == 0) r = x; else r = x % y;
`ifdef ALU_SIGNED_MD_EN
      4'd14: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else begin s = $signed(x) / $signed(y); r = s; end
      end
      4'd15: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else begin s = $signed(x) % $signed(y); r = s; end
      end
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op == 4'd10 || op == 4'd11) return 33;
    if ((op == 4'd12 || op == 4'd13) && y != 0) return 33;
`ifdef ALU_SIGNED_MD_EN
    if ((op == 4'd14 || op == 4'd15) && y != 0 && !(x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 33;
`endif
    return 1;
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_ovalid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, result, e.res);
        check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
        check({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
        last_res = e.res;
      end
    end
  end

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit track);
    exp_t n;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; alucontrol = op; a = x; b = y;
    if (track) begin
      n.tag = tag; n.res = model(op, x, y); n.due = cyc + lat_of(op, x, y);
      sb.push_back(n);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    @(negedge clk); in_valid = 1'b0; #1;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic busy_watch(input string tag);
    int hi = 0;
    repeat (32) begin
      @(negedge clk); in_valid = 1'b0; #1;
      if (in_ready) hi++;
    end
    check({tag, "_busy_ready"}, 32'(hi), 32'd0);
  endtask

  task automatic run_iter(input string tag, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    issue(tag, op, x, y, 1'b1);
    busy_watch(tag);
    drain(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; alucontrol = 4'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;

    issue("add", 4'd0, 32'd5, 32'd7, 1'b1);
    drain("add");

    // back-to-back single-cycle ops
    issue("sub", 4'd1, 32'd3, 32'd3, 1'b1);
    issue("sra", 4'd8, 32'h8000_0000, 32'd4, 1'b1);
    issue("sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 1'b1);
    drain("b2b");

    issue("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1);
    issue("or", 4'd3, 32'hF000_0001, 32'h0000_00F0, 1'b1);
    issue("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
    issue("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("sltu_ff", 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue("sll", 4'd6, 32'd3, 32'd31, 1'b1);
    issue("srl", 4'd7, 32'h8000_0000, 32'h0000_0023, 1'b1);
    issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    drain("misc");

    run_iter("mul", 4'd10, 32'h0001_0000, 32'h0001_0000);
    run_iter("mulhu", 4'd11, 32'h0001_0000, 32'h0001_0000);
    run_iter("divu", 4'd12, 32'd100, 32'd7);
    run_iter("remu", 4'd13, 32'd100, 32'd7);

    issue("divu0", 4'd12, 32'd9, 32'd0, 1'b1);
    issue("remu0", 4'd13, 32'd9, 32'd0, 1'b1);
    drain("div0");

    // flush at BUSY cycle 10 of a divide
    issue("flush_divu", 4'd12, 32'd1000, 32'd3, 1'b0);
    repeat (10) begin @(negedge clk); in_valid = 1'b0; end
    flush = 1'b1; #1;
    check("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk); flush = 1'b0; #1;
    check("flush_idle_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_result_held", result, last_res);
    repeat (40) @(negedge clk);
    check("flush_result_later", result, last_res);

    // reset in the middle of a multiply
    issue("rst_mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (5) begin @(negedge clk); in_valid = 1'b0; end
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    run_iter("mul_ff", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_iter("mulhu_ff", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_iter("divu_big", 4'd12, 32'hFFFF_FFFF, 32'd16);
    run_iter("remu_big", 4'd13, 32'hDEAD_BEEF, 32'd1000);

`ifdef ALU_SIGNED_MD_EN
    run_iter("div_neg", 4'd14, 32'hFFFF_FFF9, 32'd2);
    run_iter("rem_neg", 4'd15, 32'hFFFF_FFF9, 32'd2);
    run_iter("div_negb", 4'd14, 32'd100, 32'hFFFF_FFF9);
    run_iter("rem_negb", 4'd15, 32'd100, 32'hFFFF_FFF9);
    issue("div_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("rem_ovf", 4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("div_s0", 4'd14, 32'hFFFF_FFF9, 32'd0, 1'b1);
    issue("rem_s0", 4'd15, 32'hFFFF_FFF9, 32'd0, 1'b1);
    drain("signed_fast");
`else
    issue("op14", 4'd14, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue("op15", 4'd15, 32'hFFFF_FFF9, 32'd2, 1'b1);
    drain("illegal");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
